mult_channel_pipe: RTL and testbench
====================================

# mult_channel_pipe

Parametrised, multi-channel element-wise multiplier stage for the sparse matrix-vector datapath, sitting between the per-channel matrix/vector value FIFOs and the reduction logic. Each channel pops one matrix value and one vector value, multiplies them signed through a configurable-depth pipeline, and buffers the result in its own output FIFO. In accumulate mode, the channel sums products until a row-end flag and emits one saturated dot-product per row. Credit-based issue guarantees the output FIFO can never overflow with products still in flight.

## Interface
- CHANNELS, 4: number of independent channels.
- VAL_BITS, 16: signed width of matrix and vector values.
- OUT_BITS, 40: signed width of the output word; must be ≥ 2*VAL_BITS.
- PIPE_STAGES, 2: multiplier register stages, range 1..4.
- FIFO_DEPTH, 16: output FIFO depth per channel, power of two ≥ 4.
- ACC_MODE, 0: 0 = emit every product; 1 = accumulate until row end.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-low (0 = reset).
- vec  in  CHANNELS*VAL_BITS  vector value for each channel; slice i is [i*VAL_BITS +: VAL_BITS].
- vec_fifo_empty  in  CHANNELS  per-channel: vector FIFO is empty.
- vec_fifo_read  out  CHANNELS  per-channel pop strobe to the vector FIFO.
- mat  in  CHANNELS*VAL_BITS  matrix value for each channel.
- mat_last  in  CHANNELS  per-channel: this matrix value ends a row (used only when ACC_MODE=1).
- mat_fifo_empty  in  CHANNELS  per-channel: matrix FIFO is empty.
- mat_fifo_read  out  CHANNELS  per-channel pop strobe to the matrix FIFO.
- mult  out  CHANNELS*OUT_BITS  head word of each output FIFO, first-word-fall-through.
- mult_fifo_empty  out  CHANNELS  per-channel: output FIFO is empty.
- mult_fifo_read  in  CHANNELS  per-channel pop strobe from downstream.
- sat_flag  out  CHANNELS  sticky per-channel flag: the accumulator saturated.

## Operation
- Input FIFOs are first-word-fall-through: data is valid whenever the FIFO is not empty, and the read strobe pops it at the clock edge.
- Channels are fully independent; a stall on one channel never affects another.
- Issue condition for channel i: ~vec_fifo_empty[i] & ~mat_fifo_empty[i] & credit_ok[i] & rst.
  - vec_fifo_read[i] = mat_fifo_read[i] = issue[i]. Both are combinational and forced to 0 while rst=0.
- Credit accounting:
  - reserved[i] = output FIFO occupancy + in-flight beats that will write the FIFO.
  - Which beats reserve a slot: every beat when ACC_MODE=0; only beats with mat_last=1 when ACC_MODE=1.
  - credit_ok[i] = (reserved[i] < FIFO_DEPTH), or the beat does not reserve a slot.
  - A pop and a reserving issue in the same cycle leave reserved[i] unchanged.
- Arithmetic: the product is the full signed 2*VAL_BITS result, sign-extended to OUT_BITS.
- ACC_MODE=0: each product is written to the output FIFO as it leaves the pipeline.
- ACC_MODE=1:
  - Per-channel accumulator is OUT_BITS wide, with a two-state FSM per channel: IDLE (acc==0, no row open) and ACCUM.
  - A beat without last adds its product into acc and moves the FSM to ACCUM.
  - A beat with last writes sat(acc+product) to the FIFO, clears acc to 0, and returns the FSM to IDLE. A single-element row goes IDLE→IDLE and emits just its product.
  - Saturation: on signed overflow, the result clamps to +2^(OUT_BITS-1)-1 or -2^(OUT_BITS-1), and sat_flag[i] sets. sat_flag clears only on reset.
- Output FIFO (per channel, circular, FIFO_DEPTH entries):
  - A read while empty is ignored.
  - A write is never attempted while full; credits guarantee this, and the bench asserts it.
  - A simultaneous read and write keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (rst=0 at an edge):
  - Pipeline valids, accumulators, FIFO pointers and occupancy, reserved counters and sat_flag all go to 0; FSMs go to IDLE.
  - Reset outputs: mult_fifo_empty=all 1s, read strobes=0, mult=0, sat_flag=0.
  - Reset mid-row discards the partial accumulation and any in-flight products.

## Timing
- Issue at edge t: the product is in stage PIPE_STAGES at t+PIPE_STAGES, and the FIFO write occurs on that edge.
- mult_fifo_empty[i] deasserts in the cycle after t+PIPE_STAGES. Issue-to-visible latency is PIPE_STAGES+1 cycles.
- ACC_MODE=1: accumulation happens in the final pipeline stage with no extra latency. Back-to-back beats, one per cycle, are sustained with no bubbles.
- Throughput: one beat per channel per cycle while credits are available and downstream pops every cycle.
- A pop in cycle c frees its credit for an issue in the same cycle c (combinational credit check).

## Test plan
- ACC_MODE=0, PIPE_STAGES=2: channel 0 gets mat=3, vec=-5 → mult[0]=-15 (sign-extended), mult_fifo_empty[0] falls exactly 3 cycles after issue; the other channels stay empty.
- Backpressure: mult_fifo_read=0 and 20 beats on channel 1 with FIFO_DEPTH=16 → exactly 16 issues, no overflow, 4 beats stall. Then pop once per cycle → all 20 products arrive in order.
- ACC_MODE=1: row of (2,3),(4,5),(-1,6) with last on the third beat → one output of 20, FSM back in IDLE. Then a single-element row (7,7) → 49.
- Saturation with VAL_BITS=16, OUT_BITS=32: accumulate (-32768,-32768) three times with last on the third beat → output 2147483647, sat_flag=1. The flag persists until rst=0.
- Simultaneous events: channel at reserved=FIFO_DEPTH, downstream pops and a new beat is available in the same cycle → the issue occurs that cycle and occupancy is unchanged. A read while empty is ignored.
- Reset mid-row: rst=0 for 1 cycle after 2 of 3 beats → all FIFOs empty and read strobes 0. The next row (1,1),(1,1) with last on the second beat → output 2, with no leftover partial sum.

Source files
------------

// File: rtl/mult_channel_pipe.sv
// Multi-channel signed multiplier stage with optional row accumulation.
// Each channel has a credit-guarded pipeline feeding its own FWFT output FIFO.
module mult_channel_pipe #(
  parameter int CHANNELS    = 4,
  parameter int VAL_BITS    = 16,
  parameter int OUT_BITS    = 40,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACC_MODE    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*VAL_BITS-1:0] vec,
  input  logic [CHANNELS-1:0]          vec_fifo_empty,
  output logic [CHANNELS-1:0]          vec_fifo_read,
  input  logic [CHANNELS*VAL_BITS-1:0] mat,
  input  logic [CHANNELS-1:0]          mat_last,
  input  logic [CHANNELS-1:0]          mat_fifo_empty,
  output logic [CHANNELS-1:0]          mat_fifo_read,
  output logic [CHANNELS*OUT_BITS-1:0] mult,
  output logic [CHANNELS-1:0]          mult_fifo_empty,
  input  logic [CHANNELS-1:0]          mult_fifo_read,
  output logic [CHANNELS-1:0]          sat_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int PB = 2 * VAL_BITS;
  localparam int MSB = OUT_BITS - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic signed [OUT_BITS-1:0] SAT_MAX =
    {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] SAT_MIN =
    {1'b1, {(OUT_BITS-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} acc_state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic signed [VAL_BITS-1:0] a;
    logic signed [VAL_BITS-1:0] b;
    logic signed [PB-1:0]       prod;
    logic                       reserves;
    logic                       pop;
    logic                       credit_ok;
    logic                       issue;
    logic [CW-1:0]              reserved;
    logic [CW-1:0]              count;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [OUT_BITS-1:0]        mem [FIFO_DEPTH];
    logic [PIPE_STAGES-1:0]     pv;
    logic [PIPE_STAGES-1:0]     pl;
    logic signed [OUT_BITS-1:0] pd [PIPE_STAGES];
    logic signed [OUT_BITS-1:0] tail;
    logic signed [OUT_BITS-1:0] acc;
    logic signed [OUT_BITS-1:0] acc_nx;
    logic signed [OUT_BITS-1:0] acc_base;
    logic signed [OUT_BITS-1:0] sum;
    logic signed [OUT_BITS-1:0] sat_sum;
    logic signed [OUT_BITS-1:0] wdata;
    logic                       tail_v;
    logic                       tail_l;
    logic                       ovf;
    logic                       wr;
    logic                       sat_q;
    logic                       sat_nx;
    logic                       empty;
    acc_state_e                 state;
    acc_state_e                 state_nx;

    assign a = mat[i*VAL_BITS +: VAL_BITS];
    assign b = vec[i*VAL_BITS +: VAL_BITS];
    assign prod = a * b;

    // A same-cycle pop returns its slot before the credit check.
    assign empty     = (count == '0);
    assign pop       = mult_fifo_read[i] & ~empty;
    assign reserves  = (ACC_MODE == 0) | mat_last[i];
    assign credit_ok = ~reserves | pop | (reserved < DEPTH_C);
    assign issue     = rst & ~vec_fifo_empty[i] & ~mat_fifo_empty[i]
                       & credit_ok;

    assign vec_fifo_read[i] = issue;
    assign mat_fifo_read[i] = issue;

    always_ff @(posedge clk) begin
      if (!rst) begin
        pv <= '0;
        pl <= '0;
      end else begin
        pv[0] <= issue;
        pl[0] <= mat_last[i];
        for (int s = 1; s < PIPE_STAGES; s++) begin
          pv[s] <= pv[s-1];
          pl[s] <= pl[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= OUT_BITS'(prod);
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pd[s] <= pd[s-1];
      end
    end

    assign tail   = pd[PIPE_STAGES-1];
    assign tail_v = pv[PIPE_STAGES-1];
    assign tail_l = pl[PIPE_STAGES-1];

    // Accumulation lives in the last stage; IDLE implies a zero base.
    assign acc_base = (state == ACCUM) ? acc : '0;
    assign sum      = acc_base + tail;
    assign ovf      = (acc_base[MSB] == tail[MSB])
                      & (sum[MSB] != acc_base[MSB]);
    assign sat_sum  = ovf ? (acc_base[MSB] ? SAT_MIN : SAT_MAX) : sum;

    always_comb begin
      state_nx = state;
      acc_nx   = acc;
      sat_nx   = sat_q;
      if ((ACC_MODE != 0) && tail_v) begin
        sat_nx = sat_q | ovf;
        unique case (state)
          IDLE, ACCUM: begin
            state_nx = tail_l ? IDLE : ACCUM;
            acc_nx   = tail_l ? '0 : sat_sum;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state <= IDLE;
        acc   <= '0;
        sat_q <= 1'b0;
      end else begin
        state <= state_nx;
        acc   <= acc_nx;
        sat_q <= sat_nx;
      end
    end

    assign wr    = tail_v & ((ACC_MODE == 0) | tail_l);
    assign wdata = (ACC_MODE != 0) ? sat_sum : tail;

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        reserved <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count    <= count + CW'(wr) - CW'(pop);
        reserved <= reserved + CW'(issue & reserves) - CW'(pop);
      end
    end

    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wdata;
    end

    assign mult[i*OUT_BITS +: OUT_BITS] = empty ? '0 : mem[rd_ptr];
    assign mult_fifo_empty[i] = empty;
    assign sat_flag[i]        = sat_q;
  end

endmodule

// File: tb/tb_mult_channel_pipe.sv
// Directed bench for mult_channel_pipe: a product-mode instance
// and an accumulate-mode instance with a 32-bit output word.
module tb_mult_channel_pipe;
  localparam int CH  = 4;
  localparam int VB  = 16;
  localparam int OB0 = 40;
  localparam int OB1 = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH*VB-1:0]  vec0, mat0, vec1, mat1;
  logic [CH-1:0]     vfe0, mfe0, vfr0, mfr0, ml0, me0, mrd0, sat0;
  logic [CH-1:0]     vfe1, mfe1, vfr1, mfr1, ml1, me1, mrd1, sat1;
  logic [CH*OB0-1:0] mu0;
  logic [CH*OB1-1:0] mu1;

  int checks = 0;
  int failures = 0;

  mult_channel_pipe #(
    .CHANNELS(CH), .VAL_BITS(VB), .OUT_BITS(OB0),
    .PIPE_STAGES(2), .FIFO_DEPTH(16), .ACC_MODE(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .vec(vec0), .vec_fifo_empty(vfe0), .vec_fifo_read(vfr0),
    .mat(mat0), .mat_last(ml0), .mat_fifo_empty(mfe0),
    .mat_fifo_read(mfr0), .mult(mu0), .mult_fifo_empty(me0),
    .mult_fifo_read(mrd0), .sat_flag(sat0)
  );

  mult_channel_pipe #(
    .CHANNELS(CH), .VAL_BITS(VB), .OUT_BITS(OB1),
    .PIPE_STAGES(2), .FIFO_DEPTH(16), .ACC_MODE(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .vec(vec1), .vec_fifo_empty(vfe1), .vec_fifo_read(vfr1),
    .mat(mat1), .mat_last(ml1), .mat_fifo_empty(mfe1),
    .mat_fifo_read(mfr1), .mult(mu1), .mult_fifo_empty(me1),
    .mult_fifo_read(mrd1), .sat_flag(sat1)
  );

  // The output FIFO under backpressure must never see a write while full
  always @(posedge clk) begin
    if (rst && u0.g_ch[1].wr && u0.g_ch[1].count == 5'd16) begin
      failures++;
      $display("FAIL fifo_overflow ch1 write while count=%0d",
               u0.g_ch[1].count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    vec0 = '0; mat0 = '0; vec1 = '0; mat1 = '0;
    ml0 = '0; ml1 = '0; mrd0 = '0; mrd1 = '0;
    vfe0 = '0; mfe0 = '0; vfe1 = '0; mfe1 = '0;
    repeat (3) tick();
    checks++;
    if ({vfr0, mfr0} !== 8'h00)
      $display("FAIL reset_strobe0 got=%h want=00", {vfr0, mfr0});
    checks++;
    if ({vfr1, mfr1} !== 8'h00)
      $display("FAIL reset_strobe1 got=%h want=00", {vfr1, mfr1});
    checks++;
    if ({me0, me1} !== 8'hFF)
      $display("FAIL reset_empty got=%h want=ff", {me0, me1});
    checks++;
    if (mu0 !== '0 || mu1 !== '0)
      $display("FAIL reset_mult got=%h/%h want=0", mu0, mu1);
    checks++;
    if ({sat0, sat1} !== 8'h00)
      $display("FAIL reset_sat got=%h want=00", {sat0, sat1});
    if ({vfr0, vfr1, me0, me1, sat0, sat1} !== 24'h00FF00 ||
        mu0 !== '0 || mu1 !== '0)
      failures++;
    vfe0 = '1; mfe0 = '1; vfe1 = '1; mfe1 = '1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_product();
    mat0[0 +: VB] = 16'(3);
    vec0[0 +: VB] = 16'(-5);
    vfe0[0] = 1'b0; mfe0[0] = 1'b0;
    #1;
    checks++;
    if ({vfr0, mfr0} !== 8'h11) begin
      failures++;
      $display("FAIL basic_issue got=%h want=11", {vfr0, mfr0});
    end
    tick();
    vfe0[0] = 1'b1; mfe0[0] = 1'b1;
    tick();
    checks++;
    if (me0[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_early got=%b want=1", me0[0]);
    end
    tick();
    checks++;
    if (me0 !== 4'b1110) begin
      failures++;
      $display("FAIL basic_latency got=%b want=1110", me0);
    end
    checks++;
    if (mu0[0 +: OB0] !== 40'hFF_FFFF_FFF1) begin
      failures++;
      $display("FAIL basic_value got=%h want=fffffffff1", mu0[0 +: OB0]);
    end
    mrd0[0] = 1'b1;
    tick();
    mrd0[0] = 1'b0;
    checks++;
    if (me0[0] !== 1'b1 || mu0[0 +: OB0] !== '0) begin
      failures++;
      $display("FAIL basic_pop got=%b/%h want=1/0", me0[0], mu0[0 +: OB0]);
    end
  endtask

  task automatic test_backpressure();
    int mv [20];
    int vv [20];
    logic [OB0-1:0] expv [20];
    int idx = 0;
    int issued = 0;
    int rcv = 0;
    for (int k = 0; k < 20; k++) begin
      mv[k] = k * 1000 - 9000;
      vv[k] = 7 * k - 60;
      expv[k] = 40'(mv[k] * vv[k]);
    end
    mrd0[1] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mat0[VB +: VB] = 16'(mv[idx % 20]);
      vec0[VB +: VB] = 16'(vv[idx % 20]);
      vfe0[1] = (idx >= 20); mfe0[1] = (idx >= 20);
      #1;
      if (vfr0[1]) begin issued++; idx++; end
      tick();
    end
    checks++;
    if (issued !== 16) begin
      failures++;
      $display("FAIL bp_issued got=%0d want=16", issued);
    end
    // Full reservation: a pop must let a waiting beat issue that same cycle
    mat0[VB +: VB] = 16'(mv[idx]);
    vec0[VB +: VB] = 16'(vv[idx]);
    mrd0[1] = 1'b1;
    #1;
    checks++;
    if (vfr0[1] !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop_issue got=%b want=1", vfr0[1]);
    end
    checks++;
    if (mu0[OB0 +: OB0] !== expv[0]) begin
      failures++;
      $display("FAIL bp_head0 got=%h want=%h", mu0[OB0 +: OB0], expv[0]);
    end
    if (vfr0[1]) idx++;
    rcv = 1;
    tick();
    mat0[VB +: VB] = 16'(mv[idx]);
    vec0[VB +: VB] = 16'(vv[idx]);
    mrd0[1] = 1'b0;
    #1;
    checks++;
    if (vfr0[1] !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit_held got=%b want=0", vfr0[1]);
    end
    tick();
    for (int n = 0; n < 80 && rcv < 20; n++) begin
      mat0[VB +: VB] = 16'(mv[idx % 20]);
      vec0[VB +: VB] = 16'(vv[idx % 20]);
      vfe0[1] = (idx >= 20); mfe0[1] = (idx >= 20);
      mrd0[1] = 1'b1;
      #1;
      if (vfr0[1]) idx++;
      if (!me0[1]) begin
        checks++;
        if (mu0[OB0 +: OB0] !== expv[rcv]) begin
          failures++;
          $display("FAIL bp_order[%0d] got=%h want=%h",
                   rcv, mu0[OB0 +: OB0], expv[rcv]);
        end
        rcv++;
      end
      tick();
    end
    checks++;
    if (rcv !== 20 || idx !== 20) begin
      failures++;
      $display("FAIL bp_drain got=%0d/%0d want=20/20", rcv, idx);
    end
    vfe0[1] = 1'b1; mfe0[1] = 1'b1;
  endtask

  task automatic test_read_empty();
    mrd0[1] = 1'b1;
    repeat (3) tick();
    checks++;
    if (me0[1] !== 1'b1 || mu0[OB0 +: OB0] !== '0) begin
      failures++;
      $display("FAIL rd_empty got=%b/%h want=1/0", me0[1], mu0[OB0 +: OB0]);
    end
    mrd0[1] = 1'b0;
    mat0[VB +: VB] = 16'(2);
    vec0[VB +: VB] = 16'(2);
    vfe0[1] = 1'b0; mfe0[1] = 1'b0;
    tick();
    vfe0[1] = 1'b1; mfe0[1] = 1'b1;
    repeat (2) tick();
    checks++;
    if (me0[1] !== 1'b0 || mu0[OB0 +: OB0] !== 40'd4) begin
      failures++;
      $display("FAIL rd_after_empty got=%b/%h want=0/4",
               me0[1], mu0[OB0 +: OB0]);
    end
    mrd0[1] = 1'b1;
    tick();
    mrd0[1] = 1'b0;
  endtask

  task automatic run_row1(input int ch, input int n,
                          input int m [3], input int v [3]);
    for (int k = 0; k < n; k++) begin
      mat1[ch*VB +: VB] = 16'(m[k]);
      vec1[ch*VB +: VB] = 16'(v[k]);
      ml1[ch] = (k == n - 1);
      vfe1[ch] = 1'b0; mfe1[ch] = 1'b0;
      #1;
      checks++;
      if (vfr1[ch] !== 1'b1) begin
        failures++;
        $display("FAIL acc_b2b ch%0d beat%0d got=%b want=1", ch, k, vfr1[ch]);
      end
      tick();
    end
    vfe1[ch] = 1'b1; mfe1[ch] = 1'b1; ml1[ch] = 1'b0;
  endtask

  task automatic expect_out1(input int ch, input logic [OB1-1:0] want,
                             input string name);
    int n = 0;
    while (me1[ch] && n < 10) begin tick(); n++; end
    checks++;
    if (me1[ch] !== 1'b0 || mu1[ch*OB1 +: OB1] !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, mu1[ch*OB1 +: OB1], want);
    end
    mrd1[ch] = 1'b1;
    tick();
    mrd1[ch] = 1'b0;
    repeat (4) tick();
    checks++;
    if (me1[ch] !== 1'b1) begin
      failures++;
      $display("FAIL %s_single got=%b want=1", name, me1[ch]);
    end
  endtask

  task automatic test_accumulate();
    int m [3] = '{2, 4, -1};
    int v [3] = '{3, 5, 6};
    int m1 [3] = '{7, 0, 0};
    run_row1(0, 3, m, v);
    expect_out1(0, 32'd20, "acc_row");
    run_row1(0, 1, m1, m1);
    expect_out1(0, 32'd49, "acc_single");
  endtask

  task automatic test_saturation();
    int m [3] = '{-32768, -32768, -32768};
    run_row1(2, 3, m, m);
    expect_out1(2, 32'h7FFF_FFFF, "sat_value");
    checks++;
    if (sat1 !== 4'b0100) begin
      failures++;
      $display("FAIL sat_flag got=%b want=0100", sat1);
    end
    repeat (5) tick();
    checks++;
    if (sat1 !== 4'b0100) begin
      failures++;
      $display("FAIL sat_sticky got=%b want=0100", sat1);
    end
  endtask

  task automatic test_reset_mid_row();
    int m [3] = '{1, 1, 0};
    mat1[3*VB +: VB] = 16'(5); vec1[3*VB +: VB] = 16'(5);
    vfe1[3] = 1'b0; mfe1[3] = 1'b0;
    mat0[2*VB +: VB] = 16'(9); vec0[2*VB +: VB] = 16'(9);
    vfe0[2] = 1'b0; mfe0[2] = 1'b0;
    tick();
    mat1[3*VB +: VB] = 16'(6); vec1[3*VB +: VB] = 16'(6);
    vfe0[2] = 1'b1; mfe0[2] = 1'b1;
    tick();
    rst = 1'b0;
    mat1[3*VB +: VB] = 16'(7); vec1[3*VB +: VB] = 16'(7);
    vfe0[2] = 1'b0; mfe0[2] = 1'b0;
    #1;
    checks++;
    if (vfr1[3] !== 1'b0 || vfr0[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_strobe got=%b/%b want=0/0", vfr1[3], vfr0[2]);
    end
    tick();
    rst = 1'b1;
    vfe0 = '1; mfe0 = '1; vfe1 = '1; mfe1 = '1;
    checks++;
    if ({me0, me1} !== 8'hFF || sat1 !== 4'b0000) begin
      failures++;
      $display("FAIL rst_state got=%h/%b want=ff/0000", {me0, me1}, sat1);
    end
    repeat (4) tick();
    checks++;
    if (me0[2] !== 1'b1 || me1[3] !== 1'b1) begin
      failures++;
      $display("FAIL rst_inflight got=%b/%b want=1/1", me0[2], me1[3]);
    end
    run_row1(3, 2, m, m);
    expect_out1(3, 32'd2, "rst_next_row");
  endtask

  initial begin
    test_reset();
    test_basic_product();
    test_backpressure();
    test_read_empty();
    test_accumulate();
    test_saturation();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
